// File: rtl/sram_lsu_pkg.sv
// Shared funct3 encodings, FSM state type and request legality helper for sram_lsu.
package sram_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/sram_lsu_if.sv
// Request/response handshake bundle between a requester (master) and sram_lsu (slave).
interface sram_lsu_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/sram_lsu_ext.sv
// Load data extract/extend: picks the low byte/halfword/word of the SRAM word and sign- or zero-extends.
module sram_lsu_ext
    import sram_lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);

    always_comb begin
        o_data = '0;
        case (i_funct3)
            F3_B:    o_data = {{24{i_rdata[7]}}, i_rdata[7:0]};
            F3_H:    o_data = {{16{i_rdata[15]}}, i_rdata[15:0]};
            F3_W:    o_data = i_rdata;
            F3_BU:   o_data = {24'h0, i_rdata[7:0]};
            F3_HU:   o_data = {16'h0, i_rdata[15:0]};
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/sram_lsu.sv
// Single-outstanding load/store unit in front of a byte-addressed SRAM (IDLE -> ACCESS -> RESP).
// Optional alignment checking: define SRAM_LSU_MISALIGN_CHECK_EN.
module sram_lsu
    import sram_lsu_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    sram_lsu_if.slave         bus,
    output logic [ADDR_W-1:0] sram_address,
    output logic [3:0]        sram_w_en,
    output logic [31:0]       sram_write_data,
    input  logic [31:0]       sram_read_data
);

    state_t            r_state;
    logic              r_req_ready;
    logic              r_we;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_err;
    logic [3:0]        r_wen;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [31:0]       r_rsp_rdata;

    logic              w_err;
    logic [3:0]        w_mask;
    logic [31:0]       w_ext;

    function automatic logic [3:0] f3_mask(input logic [2:0] f3);
        case (f3)
            F3_B:    return 4'b0001;
            F3_H:    return 4'b0011;
            F3_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    always_comb begin
        w_err = !f3_legal(bus.req_we, bus.req_funct3);
`ifdef SRAM_LSU_MISALIGN_CHECK_EN
        if (((bus.req_funct3 == F3_H) || (bus.req_funct3 == F3_HU)) && bus.req_addr[0]) begin
            w_err = 1'b1;
        end
        if ((bus.req_funct3 == F3_W) && (bus.req_addr[1:0] != 2'b00)) begin
            w_err = 1'b1;
        end
`endif
        w_mask = (bus.req_we && !w_err) ? f3_mask(bus.req_funct3) : 4'b0000;
    end

    sram_lsu_ext u_ext (
        .i_funct3 (r_funct3),
        .i_rdata  (sram_read_data),
        .o_data   (w_ext)
    );

    // Write mask is precomputed at accept so it is only ever non-zero during ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_we        <= 1'b0;
            r_funct3    <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_err       <= 1'b0;
            r_wen       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid && r_req_ready) begin
                        r_we        <= bus.req_we;
                        r_funct3    <= bus.req_funct3;
                        r_addr      <= bus.req_addr;
                        r_wdata     <= bus.req_wdata;
                        r_err       <= w_err;
                        r_wen       <= w_mask;
                        r_req_ready <= 1'b0;
                        r_state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    r_wen       <= '0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= r_err;
                    r_rsp_rdata <= (r_we || r_err) ? '0 : w_ext;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_wen       <= '0;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign sram_address    = r_addr;
    assign sram_write_data = r_wdata;
    // Reset gates the strobe combinationally so an interrupted store never commits.
    assign sram_w_en       = rst ? 4'b0000 : r_wen;

endmodule
